// File: rtl/map_pkg.sv
// Shared map-grid definitions: default coordinate/data widths and cell encodings.
// No logic, so no latency.
// No handshakes live here; nothing to back-pressure.
package map_pkg;

    localparam int MAP_X_W = 5;
    localparam int MAP_Y_W = 5;
    localparam int MAP_D_W = 3;

    typedef enum logic [MAP_D_W-1:0] {
        EMPTY  = 3'd0,
        WALL   = 3'd1,
        PELLET = 3'd2,
        POWER  = 3'd3
    } cell_t;

endpackage

// File: rtl/map_access_arbiter_rr_picker.sv
// Round-robin search: first set req bit at or above ptr, wrapping, as a one-hot pick.
// Purely combinational, zero latency.
// No backpressure; found is simply low when nothing is requesting.
module rr_picker
    import map_pkg::*;
#(
    parameter int W  = 2,
    parameter int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  pick,
    output logic          found
);

    logic [2*W-1:0] dbl_req;
    logic [2*W-1:0] dbl_oh;
    logic [W-1:0]   rot;
    logic [W-1:0]   rot_oh;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        dbl_req = {req, req} >> ptr;
        rot     = dbl_req[W-1:0];
        rot_oh  = rot & (~rot + W'(1));
        dbl_oh  = {rot_oh, rot_oh} << ptr;
        pick    = dbl_oh[2*W-1:W];
        found   = |req;
    end

endmodule

// File: rtl/map_access_arbiter.sv
// Arbitrates the single-port map memory: port 0 priority (starve-bounded), ports 1.. round-robin.
// gnt is combinational; mem command one cycle after grant; read data RD_LAT+2 cycles after grant.
// Requesters hold req until gnt; no backpressure from memory, one command per cycle.
module map_access_arbiter
    import map_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int X_W        = MAP_X_W,
    parameter int Y_W        = MAP_Y_W,
    parameter int D_W        = MAP_D_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                   clock_50,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*X_W-1:0]   addr_x,
    input  logic [N_REQ*Y_W-1:0]   addr_y,
    input  logic [N_REQ*D_W-1:0]   wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rvalid,
    output logic [D_W-1:0]         rdata,
    output logic [X_W-1:0]         mem_x,
    output logic [Y_W-1:0]         mem_y,
    output logic [D_W-1:0]         mem_wdata,
    output logic                   mem_we,
    output logic                   mem_en,
    input  logic [D_W-1:0]         mem_rdata
);

    localparam int W    = N_REQ - 1;
    localparam int PW   = (W > 1) ? $clog2(W) : 1;
    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

    typedef struct packed {
        logic           we;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] d;
    } cmd_t;

    // rr_ptr is zero-based over ports 1..N_REQ-1, so reset value 0 means port 1.
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_ptr_nxt;
    logic [SC_W-1:0] starve_cnt;
    logic [W-1:0]    rr_pick;
    logic            rr_found;
    logic            others_req;
    cmd_t            sel_cmd;
    cmd_t            cmd_q;
    logic [N_REQ-1:0] rd_pipe [RD_LAT+1];

    assign others_req = |req[N_REQ-1:1];

    rr_picker #(.W(W), .PW(PW)) u_rr_picker (
        .req   (req[N_REQ-1:1]),
        .ptr   (rr_ptr),
        .pick  (rr_pick),
        .found (rr_found)
    );

    always_comb begin
        gnt = '0;
        if (req[0] && ((starve_cnt < STARVE_MAX) || !others_req)) begin
            gnt[0] = 1'b1;
        end else if (rr_found) begin
            gnt[N_REQ-1:1] = rr_pick;
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        for (int j = 0; j < W; j++) begin
            if (gnt[j+1]) rr_ptr_nxt = (j == W - 1) ? '0 : PW'(j + 1);
        end
    end

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_cmd.we = we[i];
                sel_cmd.x  = addr_x[i*X_W +: X_W];
                sel_cmd.y  = addr_y[i*Y_W +: Y_W];
                sel_cmd.d  = wdata[i*D_W +: D_W];
            end
        end
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
            if (!others_req || (|gnt[N_REQ-1:1])) begin
                starve_cnt <= '0;
            end else if (gnt[0] && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    // Address/data hold between commands; only the strobes return to zero.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            cmd_q  <= '0;
            mem_en <= 1'b0;
        end else begin
            mem_en <= |gnt;
            if (|gnt) begin
                cmd_q <= sel_cmd;
            end else begin
                cmd_q.we <= 1'b0;
            end
        end
    end

    assign mem_we    = cmd_q.we;
    assign mem_x     = cmd_q.x;
    assign mem_y     = cmd_q.y;
    assign mem_wdata = cmd_q.d;

    // One-hot port tags ride alongside the memory latency; empty entry means no read.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= RD_LAT; i++) rd_pipe[i] <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rd_pipe[0] <= gnt & ~we;
            for (int i = 1; i <= RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            rvalid <= rd_pipe[RD_LAT];
            if (|rd_pipe[RD_LAT]) rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_map_access_arbiter.sv
// Scoreboard bench for map_access_arbiter with a behavioural map memory and arbitration model.
module tb_map_access_arbiter;

    localparam int N   = 3;
    localparam int XW  = 5;
    localparam int YW  = 5;
    localparam int DW  = 3;
    localparam int LIM = 4;
    localparam int RDL = 1;

    logic              clock_50 = 1'b0;
    logic              resetn   = 1'b0;
    logic [N-1:0]      req      = '0;
    logic [N-1:0]      we       = '0;
    logic [N*XW-1:0]   addr_x   = '0;
    logic [N*YW-1:0]   addr_y   = '0;
    logic [N*DW-1:0]   wdata    = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic [XW-1:0]     mem_x;
    logic [YW-1:0]     mem_y;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic              mem_en;
    logic [DW-1:0]     mem_rdata = '0;

    always #5 clock_50 = ~clock_50;

    map_access_arbiter #(
        .N_REQ(N), .X_W(XW), .Y_W(YW), .D_W(DW), .RD_LAT(RDL), .STARVE_LIM(LIM)
    ) dut (
        .clock_50(clock_50), .resetn(resetn), .req(req), .we(we),
        .addr_x(addr_x), .addr_y(addr_y), .wdata(wdata), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .mem_x(mem_x), .mem_y(mem_y),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
        .mem_rdata(mem_rdata)
    );

    // Unwritten cells read as (x+y) mod 8, so cell (3,7) holds 2.
    function automatic logic [DW-1:0] init_cell(input int x, input int y);
        return DW'((x + y) % 8);
    endfunction

    // Behavioural map memory with one cycle read latency.
    logic [DW-1:0] mem_arr [32][32];
    bit            mem_wr  [32][32];
    always @(posedge clock_50) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_x][mem_y] <= mem_wdata;
                mem_wr[mem_x][mem_y]  <= 1'b1;
            end else begin
                mem_rdata <= mem_wr[mem_x][mem_y] ? mem_arr[mem_x][mem_y]
                                                  : init_cell(int'(mem_x), int'(mem_y));
            end
        end
    end

    int cyc = 0;
    always @(posedge clock_50) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    typedef struct {
        logic          we;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [DW-1:0] d;
        int            due;
    } cmd_exp_t;

    rd_exp_t  rd_q[$];
    cmd_exp_t cmd_q[$];

    // Reference view of the map as seen in grant order.
    logic [DW-1:0] shadow    [32][32];
    bit            shadow_wr [32][32];

    int m_ptr    = 1;
    int m_starve = 0;

    function automatic int model_pick();
        bit others = (req[N-1:1] != 0);
        if (req[0] && (m_starve < LIM || !others)) return 0;
        for (int i = 0; i < N - 1; i++) begin
            int p = m_ptr + i;
            if (p > N - 1) p -= (N - 1);
            if (req[p]) return p;
        end
        return -1;
    endfunction

    // Evaluate the current cycle's inputs: check gnt, log expectations, advance the model.
    task automatic step();
        int            k;
        bit            others;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [DW-1:0] d;
        cmd_exp_t      c;
        rd_exp_t       r;
        #1;
        others = (req[N-1:1] != 0);
        k = model_pick();
        chk("gnt", 32'(gnt), (k < 0) ? 32'd0 : (32'd1 << k));
        if (k >= 0) begin
            x = addr_x[k*XW +: XW];
            y = addr_y[k*YW +: YW];
            d = wdata[k*DW +: DW];
            c.we = we[k]; c.x = x; c.y = y; c.d = d; c.due = cyc + 1;
            cmd_q.push_back(c);
            if (we[k]) begin
                shadow[x][y]    = d;
                shadow_wr[x][y] = 1'b1;
            end else begin
                r.port = k;
                r.data = shadow_wr[x][y] ? shadow[x][y] : init_cell(int'(x), int'(y));
                r.due  = cyc + 2 + RDL;
                rd_q.push_back(r);
            end
            if (k == 0) begin
                if (others) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            end else begin
                m_ptr    = (k == N - 1) ? 1 : k + 1;
                m_starve = 0;
            end
        end
        if (!others) m_starve = 0;
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic set_port(input int i, input bit r, input bit w,
                            input int x, input int y, input int d);
        req[i]               = r;
        we[i]                = w;
        addr_x[i*XW +: XW]   = XW'(x);
        addr_y[i*YW +: YW]   = YW'(y);
        wdata[i*DW +: DW]    = DW'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            req = '0;
            we  = '0;
            step();
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_mem_x", 32'(mem_x), 0);
        chk("rst_mem_y", 32'(mem_y), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a command or read data.
    always @(negedge clock_50) begin
        if (resetn) begin
            if (mem_en) begin
                if (cmd_q.size() == 0) begin
                    chk("mem_en_unexpected", 32'(mem_en), 0);
                end else begin
                    cmd_exp_t c;
                    c = cmd_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(c.we));
                    chk("mem_x", 32'(mem_x), 32'(c.x));
                    chk("mem_y", 32'(mem_y), 32'(c.y));
                    if (c.we) chk("mem_wdata", 32'(mem_wdata), 32'(c.d));
                    chk("cmd_cycle", cyc, c.due);
                end
            end else begin
                chk("mem_we_idle", 32'(mem_we), 0);
                if (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
                    chk("cmd_missing", 32'(mem_en), 1);
                    void'(cmd_q.pop_front());
                end
            end
            if (|rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 0);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rvalid_port", 32'(rvalid), 32'd1 << e.port);
                    chk("rdata", 32'(rdata), 32'(e.data));
                    chk("rd_cycle", cyc, e.due);
                end
            end else if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
                chk("rvalid_missing", 32'(rvalid), 32'd1 << rd_q[0].port);
                void'(rd_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clock_50);
        #1;
        check_reset_vals();
        tick();
        resetn = 1'b1;

        // Single read of cell (3,7) from port 1.
        tick();
        set_port(1, 1, 0, 3, 7, 0);
        step();
        idle(4);

        // Port 2 writes (10,4)=5 then reads it back.
        tick();
        set_port(2, 1, 1, 10, 4, 5);
        step();
        tick();
        set_port(2, 1, 0, 10, 4, 0);
        step();
        idle(4);

        // Round-robin between ports 1 and 2.
        for (int i = 0; i < 8; i++) begin
            tick();
            set_port(1, 1, 0, i, 1, 0);
            set_port(2, 1, 0, i, 2, 0);
            step();
            chk("rr_pattern", 32'(gnt), (i % 2 == 0) ? 32'b010 : 32'b100);
        end
        idle(4);

        // Port 0 priority bounded by the starvation limit.
        for (int i = 0; i < 15; i++) begin
            tick();
            set_port(0, 1, 0, i, 3, 0);
            set_port(1, 1, 0, i, 4, 0);
            step();
            chk("starve_pattern", 32'(gnt), (i % 5 == 4) ? 32'b010 : 32'b001);
        end
        idle(4);

        // Back-to-back reads from ports 0, 1, 2.
        for (int p = 0; p < N; p++) begin
            tick();
            req = '0;
            set_port(p, 1, 0, 5 + p, 9, 0);
            step();
        end
        idle(5);

        // Randomised traffic over a small address window to exercise read-after-write.
        for (int i = 0; i < 400; i++) begin
            tick();
            for (int p = 0; p < N; p++) begin
                set_port(p, ($urandom_range(0, 99) < 55), ($urandom_range(0, 3) == 0),
                         $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            step();
        end
        idle(6);

        // Reset while a read is in flight: it must never come back.
        tick();
        req = '0;
        set_port(1, 1, 0, 3, 7, 0);
        step();
        tick();
        req    = '0;
        resetn = 1'b0;
        rd_q.delete();
        cmd_q.delete();
        m_ptr    = 1;
        m_starve = 0;
        #1;
        check_reset_vals();
        tick();
        check_reset_vals();
        tick();
        resetn = 1'b1;
        idle(6);

        // Recovery after reset.
        tick();
        set_port(2, 1, 0, 10, 4, 0);
        step();
        idle(6);

        chk("rd_drained", rd_q.size(), 0);
        chk("cmd_drained", cmd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
Shares the single-port map grid memory (MapController) between several requesters: display scan (port 0), Pacman movement logic (port 1) and ghost logic (port 2+). Each cycle it grants at most one request, drives a registered command into the memory, and returns read data to the winning requester with a tagged valid pulse. Port 0 (display) has fixed priority, bounded by an anti-starvation counter; the remaining ports are served round-robin.

Parameters:
N_REQ, 3, number of requesters (2..8); port 0 is the priority port
X_W, 5, grid x address width
Y_W, 5, grid y address width
D_W, 3, grid cell data width
RD_LAT, 1, memory read latency in cycles from mem_* command to mem_rdata valid (1..4)
STARVE_LIM, 4, maximum consecutive port-0 grants while any other port is requesting

Ports:
clock_50  in  1  system clock, all logic on its rising edge
resetn  in  1  asynchronous active-low reset
req  in  N_REQ  per-port request, held until granted
we  in  N_REQ  per-port write (1) / read (0)
addr_x  in  N_REQ*X_W  packed per-port x, port i at [i*X_W +: X_W]
addr_y  in  N_REQ*Y_W  packed per-port y
wdata  in  N_REQ*D_W  packed per-port write data
gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
rvalid  out  N_REQ  one-hot read-data-valid pulse, registered
rdata  out  D_W  read data, valid when any rvalid bit is set
mem_x  out  X_W  memory x address, registered
mem_y  out  Y_W  memory y address, registered
mem_wdata  out  D_W  memory write data, registered
mem_we  out  1  memory write strobe, registered, one cycle
mem_en  out  1  memory command valid, registered, one cycle
mem_rdata  in  D_W  memory read data

Behaviour:
- Reset (async assert, sync deassert in the reset tree): gnt=0, rvalid=0, rdata=0, mem_x/mem_y/mem_wdata=0, mem_we=0, mem_en=0, RR pointer=1, starve counter=0, tag pipeline cleared.
- Handshake: requester asserts req[i] with stable we/addr/wdata; the transfer occurs in the cycle gnt[i]=1. The requester may drop req or present a new request on the next cycle; back-to-back grants to the same port are legal.
- gnt is a pure function of req, RR pointer and starve counter; gnt=0 when req=0. Never more than one bit set.
- Selection: if req[0] and (starve counter < STARVE_LIM or no other port requesting) → grant 0. Else grant the first requesting port in {1..N_REQ-1}, searching upward from the RR pointer and wrapping from N_REQ-1 to 1.
- RR pointer: after a grant to port k≥1, pointer = k+1, wrapping to 1 after N_REQ-1. Unchanged on port-0 grants or idle cycles.
- Starve counter: increments (saturating at STARVE_LIM) on a port-0 grant while any req[1..] is high; clears on any grant to port ≥1 and on any cycle with req[1..]=0.
- Command: a grant in cycle t produces mem_en=1, mem_we=we[k], mem_x/mem_y/mem_wdata = port k fields in cycle t+1. With no grant, mem_en=0 and mem_we=0; address/data registers hold their values.
- Reads: a shift pipeline of depth RD_LAT+1 carries {valid, port id}. rvalid[k]=1 and rdata=mem_rdata (registered) in cycle t+2+RD_LAT; 3 cycles after grant with RD_LAT=1. Writes produce no rvalid.
- Throughput: one command per cycle. Reads are returned in grant order; multiple reads can be in flight.
- rdata holds its last value when rvalid=0.
- Reset mid-operation: in-flight reads are discarded and no rvalid is emitted after reset.
- A req bit that drops before it is granted is simply not served; there is no error.

Decomposition:
- map_pkg (shared package): X_W, Y_W and D_W defaults, and the cell encodings (EMPTY, WALL, PELLET, POWER). The block does not decode cells.
- Sub-module rr_picker: a combinational priority search over N_REQ-1 bits with pointer input, returning a one-hot result and a found flag. Instantiated once, for ports 1..N_REQ-1.

Test Plan:
- Single read: port1 req, we=0, x=3, y=7, memory cell(3,7)=2 → gnt=3'b010 in cycle 0; mem_en=1, mem_x=3, mem_y=7 in cycle 1; rvalid=3'b010, rdata=2 in cycle 3.
- Write then read-back: port2 writes (10,4)=5 in cycle 0, port2 reads (10,4) in cycle 1 → mem_we=1 in cycle 1 only; rvalid=3'b100, rdata=5 in cycle 4.
- Round-robin: ports 1 and 2 held continuously, req0=0 → gnt sequence 010,100,010,100...
- Starvation bound: req0 and req1 held continuously → gnt sequence 001,001,001,001,010 repeating (STARVE_LIM=4).
- Pipelined reads: ports 0,1,2 each granted a read on consecutive cycles 0,1,2 → rvalid 001,010,100 in cycles 3,4,5, each with the matching data.
- Reset mid-read: grant port1 read in cycle 0, resetn=0 during cycle 1 → no rvalid in cycles 1–6; all outputs at reset values.
